// File: rtl/rle_decompressor_pkg.sv
// Shared definitions for the run-length decoder: FSM encoding and code-byte fields.
package rle_decompressor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Code byte layout: bit7 carries the bit value, bits 6:0 the run length.
    localparam int VAL_BIT = 7;
    localparam int LEN_MSB = 6;

    // Zero-length codes: value 1 flushes a partial word, value 0 does nothing.
    localparam logic [7:0] CODE_FLUSH = 8'h80;
    localparam logic [7:0] CODE_NOP   = 8'h00;

endpackage

// File: rtl/rle_fill_mask.sv
// Combinational mask of the word bits covered by a run segment: bits [fill .. fill+k-1].
module rle_fill_mask #(
    parameter int N  = 32,
    parameter int FW = 6,
    parameter int KW = 7
) (
    input  logic [FW-1:0] fill,
    input  logic [KW-1:0] k,
    output logic [N-1:0]  mask
);

    // Mark every bit position inside the half-open window [fill, fill+k).
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            if ((i >= int'(fill)) && (i < (int'(fill) + int'(k)))) begin
                mask[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rle_decompressor.sv
// Expands a byte-wide run-length stream into N-bit words, LSB first, with a
// one-cycle store pulse per word and a throttle gap between consecutive words.
module rle_decompressor
    import rle_decompressor_pkg::*;
#(
    parameter int N         = 32,
    parameter int STORE_GAP = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic         store,
    output logic [N-1:0] data
);

    localparam int FW = $clog2(N + 1);
    // Segment length never exceeds min(127, N), so the wider of the two fits it.
    localparam int KW = (FW > 7) ? FW : 7;
    localparam int GW = (STORE_GAP > 0) ? $clog2(STORE_GAP + 1) : 1;
    // The completion cycle itself is the first paused cycle, hence the minus one.
    localparam logic [GW-1:0] GAP_LOAD = GW'((STORE_GAP > 0) ? (STORE_GAP - 1) : 0);
    localparam logic [KW-1:0] N_K      = KW'(N);

    state_t        state;
    logic [N-1:0]  word;
    logic [FW-1:0] fill;
    logic [6:0]    run_left;
    logic          val;
    logic [GW-1:0] gap_cnt;
    // done: word holds a completed word that goes out on the next edge.
    logic          done;
    // flush_pend: a flush was accepted; the partial word completes next cycle.
    logic          flush_pend;

    logic [6:0]    in_len;
    logic          in_val;
    logic          accept;

    logic [N-1:0]  base_word;
    logic [FW-1:0] base_fill;
    logic [KW-1:0] room;
    logic [KW-1:0] run_k;
    logic [KW-1:0] k;
    logic [KW-1:0] fill_after;
    logic [6:0]    left_after;
    logic          full_after;
    logic [N-1:0]  mask;
    logic [N-1:0]  stepped_word;

    assign in_len   = in_data[LEN_MSB:0];
    assign in_val   = in_data[VAL_BIT];
    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready;

    rle_fill_mask #(
        .N  (N),
        .FW (FW),
        .KW (KW)
    ) u_fill_mask (
        .fill (base_fill),
        .k    (k),
        .mask (mask)
    );

    // One run step: a word being emitted this edge counts as already cleared,
    // so with no gap the next word starts filling in the same cycle.
    always_comb begin
        base_word    = done ? '0 : word;
        base_fill    = done ? '0 : fill;
        room         = N_K - KW'(base_fill);
        run_k        = KW'(run_left);
        k            = (run_k < room) ? run_k : room;
        fill_after   = KW'(base_fill) + k;
        left_after   = run_left - 7'(k);
        full_after   = (fill_after == N_K);
        stepped_word = (base_word & ~mask) | (val ? mask : '0);
    end

    // Decoder FSM with registered store/data outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            word       <= '0;
            fill       <= '0;
            run_left   <= '0;
            val        <= 1'b0;
            gap_cnt    <= '0;
            done       <= 1'b0;
            flush_pend <= 1'b0;
            store      <= 1'b0;
            data       <= '0;
        end else begin
            store <= done;
            done  <= 1'b0;
            if (done) begin
                data <= word;
                word <= '0;
                fill <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (in_len != 7'd0) begin
                            run_left <= in_len;
                            val      <= in_val;
                            state    <= ST_RUN;
                        end else if ((in_data == CODE_FLUSH) && (base_fill != '0)) begin
                            flush_pend <= 1'b1;
                            state      <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    if (flush_pend) begin
                        flush_pend <= 1'b0;
                        done       <= 1'b1;
                        if (STORE_GAP > 0) begin
                            gap_cnt <= GAP_LOAD;
                            state   <= ST_GAP;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        word     <= stepped_word;
                        fill     <= FW'(fill_after);
                        run_left <= left_after;
                        if (full_after) begin
                            done <= 1'b1;
                            if (STORE_GAP > 0) begin
                                gap_cnt <= GAP_LOAD;
                                state   <= ST_GAP;
                            end else begin
                                state <= (left_after != 7'd0) ? ST_RUN : ST_IDLE;
                            end
                        end else if (left_after == 7'd0) begin
                            state <= ST_IDLE;
                        end
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= (run_left != 7'd0) ? ST_RUN : ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
